uart_tx_ctrl: RTL and testbench

UART transmit controller that sequences one serial frame per accepted byte and owns the baud-rate divider that paces it. Sits between the byte producer (valid/ready) and the `tx` pin, replacing a free-running baud clock with a bit-tick counter that is enabled, cleared and consumed under state-machine control. Default pacing is 50 MHz / 434 ≈ 115200 baud.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_ctrl_if.sv | 11 +
 rtl/uart_tx_ctrl_baud_tick.sv | 42 ++++
 rtl/uart_tx_ctrl.sv | 138 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit controller.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit per frame.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   // 50 MHz / 434 is roughly 115200 baud
   localparam int DEF_CLK_DIV = 434;
   localparam int DEF_DATA_W  = 8;

`ifdef UART_TX_PARITY_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif

   // Frame length in clock cycles: start + data + optional parity + stop
   localparam int DEF_FRAME_CYCLES = (DEF_DATA_W + 2 + PARITY_BITS) * DEF_CLK_DIV;

   function automatic int frame_cycles(input int clk_div, input int data_w);
      return (data_w + 2 + PARITY_BITS) * clk_div;
   endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between a producer (master) and the UART transmitter (slave).
interface uart_tx_ctrl_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (output tx_data, output tx_valid, input  tx_ready);
   modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_ctrl_baud_tick.sv
// Bit-period counter: runs while enabled, pulses tick on its last count and
// wraps on the same edge; held at zero while disabled or cleared.
module baud_tick #(
   parameter int CLK_DIV = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = en && (cnt_q == LAST_CNT);

   // Next count: clear/disable win, then wrap on tick, else increment
   always_comb begin
      cnt_d = cnt_q;
      if (clr || !en) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register, cleared asynchronously by the active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a byte over valid/ready and sends one
// frame (start, data LSB first, optional parity, stop) on a registered tx pin.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_ctrl_if.slave  bus,
   output logic           tx,
   output logic           busy
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   uart_state_e       state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]  idx_q,   idx_d;
   logic              tx_q,    tx_d;
`ifdef UART_TX_PARITY_EN
   logic              par_q,   par_d;
`endif

   logic tick;
   logic accept;

   // The divider only runs mid-frame and restarts from zero at every accept
   baud_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_baud_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q != ST_IDLE),
      .clr  (accept),
      .tick (tick)
   );

   // Ready during the STOP tick lets the next frame start with no idle gap
   assign bus.tx_ready = (state_q == ST_IDLE) || ((state_q == ST_STOP) && tick);
   assign accept       = bus.tx_valid && bus.tx_ready;
   assign tx           = tx_q;
   assign busy         = (state_q != ST_IDLE);

   // Next state, shift register and registered line level for the next bit
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
         end
         ST_START: begin
            if (tick) begin
               state_d = ST_DATA;
               idx_d   = '0;
               tx_d    = shift_q[0];
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
                  tx_d    = par_q;
`else
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  shift_d = shift_q >> 1;
                  idx_d   = idx_q + 1'b1;
                  tx_d    = shift_d[0];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               state_d = ST_STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (tick) begin
               state_d = ST_IDLE;
               tx_d    = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // Accept only happens in IDLE or on the STOP tick, so it overrides both
      if (accept) begin
         state_d = ST_START;
         shift_d = bus.tx_data;
         idx_d   = '0;
         tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
         par_d   = ^bus.tx_data;
`endif
      end
   end

   // Frame state registers; reset forces the line idle high immediately
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a CLK_DIV=4 instance for most
// scenarios and a default-divider instance for full-rate pacing.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;

   uart_tx_ctrl_if #(.DATA_W(8)) bus_a ();
   uart_tx_ctrl_if #(.DATA_W(8)) bus_b ();
   logic tx_a, busy_a, tx_b, busy_b;

   uart_tx_ctrl #(.CLK_DIV(4), .DATA_W(8)) dut_a (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus_a),
      .tx   (tx_a),
      .busy (busy_a)
   );

   uart_tx_ctrl #(.DATA_W(8)) dut_b (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus_b),
      .tx   (tx_b),
      .busy (busy_b)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int sel   = 0;
   logic [7:0] stim [8];

   logic mon_tx, mon_busy, mon_ready;
   assign mon_tx    = (sel != 0) ? tx_b           : tx_a;
   assign mon_busy  = (sel != 0) ? busy_b         : busy_a;
   assign mon_ready = (sel != 0) ? bus_b.tx_ready : bus_a.tx_ready;

   // Line level at bit position pos of a frame carrying byte d
   function automatic logic model_bit(input logic [7:0] d, input int pos);
      if (pos == 0) return 1'b0;
      if (pos <= 8) return d[pos-1];
      if (PAR == 1 && pos == 9) return ^d;
      return 1'b1;
   endfunction

   task automatic set_in(input bit v, input logic [7:0] d);
      if (sel != 0) begin
         bus_b.tx_valid = v;
         bus_b.tx_data  = d;
      end else begin
         bus_a.tx_valid = v;
         bus_a.tx_data  = d;
      end
   endtask

   // Sends stim[0..n-1] gaplessly and checks every cycle of every frame
   task automatic run_stream(input string name, input int div, input int n);
      int frame;
      frame = (10 + PAR) * div;
      @(negedge clk);
      n_cmp++;
      if (mon_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s idle_ready got=%b exp=1", name, mon_ready);
      end
      set_in(1'b1, stim[0]);
      for (int k = 0; k < n * frame; k++) begin
         int   f;
         int   pos;
         logic exp_tx;
         logic exp_rdy;
         @(negedge clk);
         f       = k / frame;
         pos     = (k % frame) / div;
         exp_tx  = model_bit(stim[f], pos);
         exp_rdy = ((k % frame) == frame - 1);
         n_cmp++;
         if (mon_tx !== exp_tx) begin
            n_err++;
            $display("FAIL %s tx cyc=%0d got=%b exp=%b", name, k, mon_tx, exp_tx);
         end
         n_cmp++;
         if (mon_busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy cyc=%0d got=%b exp=1", name, k, mon_busy);
         end
         n_cmp++;
         if (mon_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL %s ready cyc=%0d got=%b exp=%b", name, k, mon_ready, exp_rdy);
         end
         // Producer swaps data right after each accept; in-flight frame must not change
         if ((k % frame) == 0) begin
            if (f + 1 < n) set_in(1'b1, stim[f+1]);
            else           set_in(1'b0, 8'($urandom));
         end
         if ((k % frame) == frame - 1)
            $display("%s frame byte=%02h len=%0d", name, stim[f], frame);
      end
      @(negedge clk);
      n_cmp++;
      if (mon_tx !== 1'b1 || mon_busy !== 1'b0 || mon_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s end_idle got tx=%b busy=%b rdy=%b exp 1/0/1", name, mon_tx, mon_busy, mon_ready);
      end
   endtask

   task automatic test_reset();
      sel = 0;
      set_in(1'b0, 8'h00);
      bus_b.tx_valid = 1'b0;
      bus_b.tx_data  = 8'h00;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
         n_err++;
         $display("FAIL reset_hold got tx=%b busy=%b exp 1/0", tx_a, busy_a);
      end
      rst = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         n_cmp++;
         if (tx_a !== 1'b1 || busy_a !== 1'b0 || bus_a.tx_ready !== 1'b1 ||
             tx_b !== 1'b1 || busy_b !== 1'b0 || bus_b.tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_idle cyc=%0d got a=%b%b%b b=%b%b%b exp 101", k,
                     tx_a, busy_a, bus_a.tx_ready, tx_b, busy_b, bus_b.tx_ready);
         end
      end
      $display("reset idle check done");
   endtask

   task automatic test_single();
      sel = 0;
      stim[0] = 8'h55;
      run_stream("single55", 4, 1);
   endtask

   task automatic test_back_to_back();
      sel = 0;
      stim[0] = 8'hA5;
      stim[1] = 8'h3C;
      run_stream("b2b", 4, 2);
   endtask

   task automatic test_parity();
      sel = 0;
      stim[0] = 8'h07;
      run_stream("par07", 4, 1);
      stim[0] = 8'h03;
      run_stream("par03", 4, 1);
   endtask

   task automatic test_random();
      sel = 0;
      for (int it = 0; it < 6; it++) begin
         int n;
         int gap;
         n   = $urandom_range(1, 4);
         gap = $urandom_range(0, 5);
         for (int i = 0; i < n; i++) stim[i] = 8'($urandom);
         run_stream("rand", 4, n);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            n_cmp++;
            if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
               n_err++;
               $display("FAIL rand_gap got tx=%b busy=%b exp 1/0", tx_a, busy_a);
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      sel = 0;
      // Bit 3 cleared so the line is low at cycle 17 when reset hits
      stim[0] = 8'($urandom) & 8'hF7;
      @(negedge clk);
      set_in(1'b1, stim[0]);
      for (int k = 0; k < 17; k++) begin
         @(negedge clk);
         if (k == 0) set_in(1'b0, 8'h00);
      end
      n_cmp++;
      if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
         n_err++;
         $display("FAIL midframe_pre got tx=%b busy=%b exp 0/1", tx_a, busy_a);
      end
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
         n_err++;
         $display("FAIL midframe_async got tx=%b busy=%b exp 1/0", tx_a, busy_a);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
         n_err++;
         $display("FAIL midframe_noresume got tx=%b busy=%b exp 1/0", tx_a, busy_a);
      end
      stim[0] = 8'hFF;
      run_stream("afterrst", 4, 1);
   endtask

   task automatic test_default_div();
      sel = 1;
      stim[0] = 8'h00;
      run_stream("div434", 434, 1);
      sel = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_parity();
      test_random();
      test_reset_midframe();
      test_default_div();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
